// File: rtl/frame_counter_pkg.sv
// Shared types for the frame_counter block: run-control state encoding.
package frame_counter_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } fc_state_e;

endpackage

// File: rtl/wrap_counter.sv
// Up-counter with synchronous clear that wraps to zero after reaching max_i.
// wrap_o flags the increment that performs the wrap.
module wrap_counter #(
    parameter int unsigned width_p = 8
) (
    input  logic               clk_i,
    input  logic               reset_ni,
    input  logic               clr_i,
    input  logic               inc_i,
    input  logic [width_p-1:0] max_i,
    output logic [width_p-1:0] val_o,
    output logic               wrap_o
);

    logic [width_p-1:0] val_q, val_d;

    assign wrap_o = inc_i && (val_q == max_i);
    assign val_o  = val_q;

    always_comb begin
        val_d = val_q;
        if (clr_i) begin
            val_d = '0;
        end else if (inc_i) begin
            val_d = wrap_o ? '0 : val_q + width_p'(1);
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            val_q <= '0;
        end else begin
            val_q <= val_d;
        end
    end

endmodule

// File: rtl/frame_counter.sv
// Counts sample strobes into frames and frames into bounded or continuous runs.
// Optional FRAME_COUNTER_TOTAL_EN adds a saturating total-sample counter output.
module frame_counter
    import frame_counter_pkg::*;
#(
    parameter int unsigned width_p        = 8,
    parameter int unsigned frames_width_p = 8
) (
    input  logic                      clk_i,
    input  logic                      reset_ni,
    input  logic                      en_i,
    input  logic                      start_i,
    input  logic                      stop_i,
    input  logic [width_p-1:0]        frame_len_i,
    input  logic [frames_width_p-1:0] num_frames_i,
    output logic [width_p-1:0]        sample_idx_o,
    output logic [frames_width_p-1:0] frame_idx_o,
    output logic                      frame_start_o,
    output logic                      frame_last_o,
    output logic                      busy_o,
    output logic                      done_o
`ifdef FRAME_COUNTER_TOTAL_EN
    ,
    output logic [width_p+frames_width_p-1:0] total_o
`endif
);

    fc_state_e                 state_q;
    logic [width_p-1:0]        len_q;
    logic [frames_width_p-1:0] num_q;

    logic accept;
    logic consume;
    logic clr;
    logic sample_wrap;
    logic frame_wrap;
    logic run_done;

    logic [width_p-1:0]        sample_max;
    logic [frames_width_p-1:0] frame_max;

    assign accept  = (state_q == StIdle) && start_i && !stop_i && (frame_len_i != '0);
    assign consume = (state_q == StRun) && en_i && !stop_i;
    assign clr     = accept || ((state_q == StRun) && stop_i);

    // num_q == 0 underflows to all-ones, which gives the natural continuous wrap.
    assign sample_max = len_q - width_p'(1);
    assign frame_max  = num_q - frames_width_p'(1);
    assign run_done   = frame_wrap && (num_q != '0);

    wrap_counter #(
        .width_p(width_p)
    ) u_sample_cnt (
        .clk_i   (clk_i),
        .reset_ni(reset_ni),
        .clr_i   (clr),
        .inc_i   (consume),
        .max_i   (sample_max),
        .val_o   (sample_idx_o),
        .wrap_o  (sample_wrap)
    );

    wrap_counter #(
        .width_p(frames_width_p)
    ) u_frame_cnt (
        .clk_i   (clk_i),
        .reset_ni(reset_ni),
        .clr_i   (clr),
        .inc_i   (sample_wrap),
        .max_i   (frame_max),
        .val_o   (frame_idx_o),
        .wrap_o  (frame_wrap)
    );

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= StIdle;
            len_q   <= '0;
            num_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        len_q   <= frame_len_i;
                        num_q   <= num_frames_i;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    if (stop_i) begin
                        state_q <= StIdle;
                    end else if (run_done) begin
                        state_q <= StDone;
                    end
                end
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy_o        = (state_q == StRun);
    assign done_o        = (state_q == StDone);
    assign frame_start_o = busy_o && (sample_idx_o == '0);
    assign frame_last_o  = busy_o && (sample_idx_o == sample_max);

`ifdef FRAME_COUNTER_TOTAL_EN
    logic [width_p+frames_width_p-1:0] total_q;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            total_q <= '0;
        end else if (accept) begin
            total_q <= '0;
        end else if (consume && (total_q != '1)) begin
            total_q <= total_q + (width_p + frames_width_p)'(1);
        end
    end

    assign total_o = total_q;
`endif

endmodule
